spram_loader: RTL and testbench

- Write-side front end for a single-port RAM (`we`/`addr`/`d` interface, one write per clock).
- Optionally clears the whole RAM to a fill value.
- Accepts an 8-bit valid/ready byte stream from the bridge/download path and packs the bytes little-endian into `dWidth` words.
- Issues one sequential RAM write per completed word, then reports done/overflow to core control logic.

---
 rtl/spram_loader_if.sv | 27 ++
 rtl/spram_loader.sv | 185 ++++++++++++++++++
 tb/tb_spram_loader.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spram_loader_if.sv
// spram_loader_if: byte-stream and RAM write bus for spram_loader.
//   Stream side : s_valid, s_ready, s_data[7:0], s_last (valid/ready, one byte per beat)
//   RAM side    : ram_we, ram_addr[aWidth-1:0], ram_d[dWidth-1:0] (one write per clock)
//   modport slave  - the loader (consumes the stream, drives the RAM bus)
//   modport master - the stream source / RAM observer
interface spram_loader_if #(
  parameter int unsigned aWidth = 10,
  parameter int unsigned dWidth = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [7:0]        s_data;
  logic              s_last;
  logic              ram_we;
  logic [aWidth-1:0] ram_addr;
  logic [dWidth-1:0] ram_d;

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, ram_we, ram_addr, ram_d
  );

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, ram_we, ram_addr, ram_d
  );
endinterface

// File: rtl/spram_loader.sv
// spram_loader: write-side front end for a single-port RAM.
// On start it optionally clears the RAM to fill_value_i, then packs an 8-bit valid/ready byte
// stream little-endian into dWidth-bit words and writes them to sequential addresses, one write
// per completed word. A partial final word is zero-padded. Bytes arriving after the RAM is full
// are dropped and flagged in overflow_o.
// Optional feature macro: SPRAM_LOADER_CLEAR_EN (defined: clear pass before loading).
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   start_i              single-cycle pulse, honoured only when idle or done
//   fill_value_i         clear pattern, sampled on start
//   bus_io               stream in / RAM write out (spram_loader_if.slave)
//   busy_o, done_o       operation in progress / finished
//   overflow_o           sticky: bytes dropped because the RAM was full
//   words_written_o      stream words written (clear writes excluded)
module spram_loader #(
  parameter int unsigned aWidth = 10,
  parameter int unsigned dWidth = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [dWidth-1:0] fill_value_i,
  spram_loader_if.slave     bus_io,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic [aWidth:0]   words_written_o
);

  localparam int unsigned BPW = dWidth / 8;
  localparam int unsigned BcW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BcW-1:0]  LastByte = BcW'(BPW - 1);
  localparam logic [aWidth:0] FullCnt  = {1'b1, {aWidth{1'b0}}};

  typedef enum logic [2:0] {StIdle, StClear, StLoad, StFlush, StDone} state_e;

  state_e            state_q, state_d;
  logic [aWidth-1:0] addr_q, addr_d;
  logic [BcW-1:0]    bcnt_q, bcnt_d;
  logic [dWidth-1:0] word_q, word_d;
  logic [dWidth-1:0] d_q, d_d;
  logic              we_q, we_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [aWidth:0]   wcnt_q, wcnt_d;

  logic              pend;
  logic [aWidth:0]   cnt_eff;
  logic              full;
  logic              xfer;
  logic [dWidth-1:0] packed_word;

`ifndef SPRAM_LOADER_CLEAR_EN
  logic unused_fill;
  assign unused_fill = ^fill_value_i;
`endif

  // A stream write issued last cycle is counted (and the address advanced) one cycle later, so
  // ram_addr shows the write address while ram_we is high. cnt_eff folds that pending write in.
  assign pend    = we_q && (state_q != StClear);
  assign cnt_eff = wcnt_q + (aWidth + 1)'(pend);
  assign full    = (cnt_eff == FullCnt);
  assign xfer    = bus_io.s_valid && ready_q && (state_q == StLoad);

  always_comb begin
    packed_word = word_q;
    for (int k = 0; k < int'(BPW); k++) begin
      if (bcnt_q == BcW'(k)) packed_word[8*k +: 8] = bus_io.s_data;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    d_d     = d_q;
    we_d    = 1'b0;
    ovf_d   = ovf_q;
    wcnt_d  = cnt_eff;
    // Hold the address at the top once full so it never wraps back to 0.
    if (pend && !full) addr_d = addr_q + 1'b1;

    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          addr_d = '0;
          bcnt_d = '0;
          word_d = '0;
          wcnt_d = '0;
          ovf_d  = 1'b0;
`ifdef SPRAM_LOADER_CLEAR_EN
          state_d = StClear;
          we_d    = 1'b1;
          d_d     = fill_value_i;
`else
          state_d = StLoad;
`endif
        end
      end
`ifdef SPRAM_LOADER_CLEAR_EN
      StClear: begin
        if (addr_q == '1) begin
          state_d = StLoad;
          addr_d  = '0;
        end else begin
          we_d   = 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
`endif
      StLoad: begin
        if (xfer) begin
          if (full) begin
            ovf_d = 1'b1;
            if (bus_io.s_last) state_d = StDone;
          end else if (bcnt_q == LastByte) begin
            we_d   = 1'b1;
            d_d    = packed_word;
            word_d = '0;
            bcnt_d = '0;
            if (bus_io.s_last) state_d = StDone;
          end else begin
            word_d = packed_word;
            bcnt_d = bcnt_q + 1'b1;
            if (bus_io.s_last) state_d = StFlush;
          end
        end
      end
      StFlush: begin
        // word_q was cleared after the last full word, so unfilled bytes are already 0x00.
        we_d    = 1'b1;
        d_d     = word_q;
        word_d  = '0;
        bcnt_d  = '0;
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StLoad);
    busy_d  = (state_d == StClear) || (state_d == StLoad) || (state_d == StFlush);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      d_q     <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      d_q     <= d_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign bus_io.s_ready  = ready_q;
  assign bus_io.ram_we   = we_q;
  assign bus_io.ram_addr = addr_q;
  assign bus_io.ram_d    = d_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign overflow_o      = ovf_q;
  assign words_written_o = wcnt_q;

endmodule

// File: tb/tb_spram_loader.sv
// Bench for spram_loader: two instances (aWidth=4/dWidth=16 and aWidth=2/dWidth=8).
// Stimulus pushes hand-computed RAM writes (address, data, negedge stamp) into per-instance
// queues; a negedge monitor pops and compares every observed ram_we.
module tb_spram_loader;

`ifdef SPRAM_LOADER_CLEAR_EN
  localparam int unsigned ClrA = 16;
  localparam int unsigned ClrB = 4;
`else
  localparam int unsigned ClrA = 0;
  localparam int unsigned ClrB = 0;
`endif

  typedef struct {
    int unsigned addr;
    int unsigned data;
    int unsigned cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [15:0] fill_a = '0;
  logic [7:0]  fill_b = '0;
  logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [4:0]  ww_a;
  logic [2:0]  ww_b;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned neg_cnt = 0;
  logic        rdy_a_n = 1'b0, rdy_b_n = 1'b0;
  wr_t         q_a[$];
  wr_t         q_b[$];
  wr_t         ea, eb;

  spram_loader_if #(.aWidth(4), .dWidth(16)) ifa ();
  spram_loader_if #(.aWidth(2), .dWidth(8))  ifb ();

  spram_loader #(.aWidth(4), .dWidth(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .start_i(start_a), .fill_value_i(fill_a), .bus_io(ifa),
    .busy_o(busy_a), .done_o(done_a), .overflow_o(ovf_a), .words_written_o(ww_a)
  );

  spram_loader #(.aWidth(2), .dWidth(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .start_i(start_b), .fill_value_i(fill_b), .bus_io(ifb),
    .busy_o(busy_b), .done_o(done_b), .overflow_o(ovf_b), .words_written_o(ww_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every RAM write must match the next queued expectation.
  always @(negedge clk) begin
    neg_cnt++;
    if (ifa.ram_we === 1'b1) begin
      if (q_a.size() == 0) chk("a_unexpected_write_addr", 32'(ifa.ram_addr), 32'hFFFF_FFFF);
      else begin
        ea = q_a.pop_front();
        chk("a_wr_addr", 32'(ifa.ram_addr), ea.addr);
        chk("a_wr_data", 32'(ifa.ram_d), ea.data);
        chk("a_wr_cycle", neg_cnt, ea.cyc);
      end
    end
    if (ifb.ram_we === 1'b1) begin
      if (q_b.size() == 0) chk("b_unexpected_write_addr", 32'(ifb.ram_addr), 32'hFFFF_FFFF);
      else begin
        eb = q_b.pop_front();
        chk("b_wr_addr", 32'(ifb.ram_addr), eb.addr);
        chk("b_wr_data", 32'(ifb.ram_d), eb.data);
        chk("b_wr_cycle", neg_cnt, eb.cyc);
      end
    end
    rdy_a_n = ifa.s_ready;
    rdy_b_n = ifb.s_ready;
  end

  task automatic start_a_op(input logic [15:0] fill);
    int unsigned n;
    @(posedge clk); #1;
    start_a = 1'b1; fill_a = fill;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int i = 0; i < int'(ClrA); i++) q_a.push_back('{i, 32'(fill), neg_cnt + 1 + i});
    n = 0;
    do begin @(negedge clk); n++; end while (ifa.s_ready !== 1'b1 && n < 100);
    chk("a_ready_latency", n, ClrA + 1);
    chk("a_busy_after_start", busy_a, 1);
    chk("a_done_after_start", done_a, 0);
  endtask

  task automatic start_b_op(input logic [7:0] fill);
    int unsigned n;
    @(posedge clk); #1;
    start_b = 1'b1; fill_b = fill;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int i = 0; i < int'(ClrB); i++) q_b.push_back('{i, 32'(fill), neg_cnt + 1 + i});
    n = 0;
    do begin @(negedge clk); n++; end while (ifb.s_ready !== 1'b1 && n < 100);
    chk("b_ready_latency", n, ClrB + 1);
  endtask

  // Drive one byte; if wr, the write (addr,data) is expected lat negedges after the handshake.
  task automatic send_a(input logic [7:0] b, input bit last, input bit wr, input int unsigned addr,
                        input int unsigned data, input int unsigned lat, output int unsigned waits);
    logic took;
    ifa.s_valid = 1'b1; ifa.s_data = b; ifa.s_last = last;
    waits = 0;
    do begin @(posedge clk); waits++; took = rdy_a_n; #1; end while (!took && waits < 50);
    chk("a_handshake", took, 1);
    if (wr) q_a.push_back('{addr, data, neg_cnt + lat});
    if (last) begin ifa.s_valid = 1'b0; ifa.s_last = 1'b0; end
  endtask

  task automatic send_b(input logic [7:0] b, input bit last, input bit wr, input int unsigned addr);
    logic took;
    int unsigned waits;
    ifb.s_valid = 1'b1; ifb.s_data = b; ifb.s_last = last;
    waits = 0;
    do begin @(posedge clk); waits++; took = rdy_b_n; #1; end while (!took && waits < 50);
    chk("b_handshake", took, 1);
    if (wr) q_b.push_back('{addr, 32'(b), neg_cnt + 1});
    if (last) begin ifb.s_valid = 1'b0; ifb.s_last = 1'b0; end
  endtask

  task automatic check_a_zero(input string tag);
    chk({tag, "_s_ready"}, ifa.s_ready, 0);
    chk({tag, "_ram_we"}, ifa.ram_we, 0);
    chk({tag, "_ram_addr"}, 32'(ifa.ram_addr), 0);
    chk({tag, "_ram_d"}, 32'(ifa.ram_d), 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_overflow"}, ovf_a, 0);
    chk({tag, "_words"}, 32'(ww_a), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned w, tot;
    ifa.s_valid = 1'b0; ifa.s_data = '0; ifa.s_last = 1'b0;
    ifb.s_valid = 1'b0; ifb.s_data = '0; ifb.s_last = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_a_zero("rst");
    chk("rst_b_ready", ifb.s_ready, 0);
    chk("rst_b_busy", busy_b, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Clear (if built in), then two full words back to back
    start_a_op(16'hA5A5);
    tot = 0;
    send_a(8'h11, 0, 0, 0, 0, 0, w);          tot += w;
    send_a(8'h22, 0, 1, 0, 32'h2211, 1, w);   tot += w;
    send_a(8'h33, 0, 0, 0, 0, 0, w);          tot += w;
    send_a(8'h44, 1, 1, 1, 32'h4433, 1, w);   tot += w;
    chk("a_b2b_cycles", tot, 4);
    repeat (2) @(negedge clk);
    chk("a_t1_done", done_a, 1);
    chk("a_t1_busy", busy_a, 0);
    chk("a_t1_ready", ifa.s_ready, 0);
    chk("a_t1_words", 32'(ww_a), 2);
    chk("a_t1_ovf", ovf_a, 0);

    // Valid while not ready must be ignored
    ifa.s_valid = 1'b1; ifa.s_data = 8'h77;
    repeat (3) @(negedge clk);
    ifa.s_valid = 1'b0;
    chk("a_ignored_words", 32'(ww_a), 2);
    chk("a_ignored_done", done_a, 1);

    // Partial final word flushed with zero padding
    start_a_op(16'h5A3C);
    chk("a_t2_words_cleared", 32'(ww_a), 0);
    send_a(8'h01, 0, 0, 0, 0, 0, w);
    send_a(8'h02, 0, 1, 0, 32'h0201, 1, w);
    send_a(8'h03, 1, 1, 1, 32'h0003, 2, w);
    repeat (3) @(negedge clk);
    chk("a_t2_done", done_a, 1);
    chk("a_t2_words", 32'(ww_a), 2);

    // Asynchronous reset in the middle of a load
    start_a_op(16'h1111);
    send_a(8'hAA, 0, 0, 0, 0, 0, w);
    send_a(8'hBB, 0, 1, 0, 32'hBBAA, 1, w);
    send_a(8'hCC, 0, 0, 0, 0, 0, w);
    ifa.s_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1 check_a_zero("midrst");
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset_n = 1'b1;
    start_a_op(16'h2222);
    chk("a_t3_ovf_after_restart", ovf_a, 0);
    send_a(8'h12, 0, 0, 0, 0, 0, w);
    send_a(8'h34, 1, 1, 0, 32'h3412, 1, w);
    repeat (2) @(negedge clk);
    chk("a_t3_words", 32'(ww_a), 1);
    chk("a_t3_done", done_a, 1);

    // Two-byte stream
    start_a_op(16'h0F0F);
    send_a(8'hFF, 0, 0, 0, 0, 0, w);
    send_a(8'hEE, 1, 1, 0, 32'hEEFF, 1, w);
    repeat (2) @(negedge clk);
    chk("a_t4_done", done_a, 1);
    chk("a_t4_words", 32'(ww_a), 1);

    // Overflow on the small instance: 6 bytes into 4 words
    start_b_op(8'h5A);
    send_b(8'h10, 0, 1, 0);
    send_b(8'h11, 0, 1, 1);
    send_b(8'h12, 0, 1, 2);
    send_b(8'h13, 0, 1, 3);
    send_b(8'h14, 0, 0, 0);
    send_b(8'h15, 1, 0, 0);
    repeat (3) @(negedge clk);
    chk("b_ovf", ovf_b, 1);
    chk("b_done", done_b, 1);
    chk("b_busy", busy_b, 0);
    chk("b_words", 32'(ww_b), 4);
    chk("b_addr_no_wrap", 32'(ifb.ram_addr), 3);

    // Next start clears the sticky overflow
    start_b_op(8'h00);
    chk("b_ovf_cleared", ovf_b, 0);
    chk("b_words_cleared", 32'(ww_b), 0);
    send_b(8'h99, 1, 1, 0);
    repeat (3) @(negedge clk);
    chk("b_t2_done", done_b, 1);
    chk("b_t2_words", 32'(ww_b), 1);

    repeat (3) @(negedge clk);
    chk("a_queue_empty", q_a.size(), 0);
    chk("b_queue_empty", q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
